// File: rtl/openhw_cnt_seq_if.sv
// Handshake bundle for openhw_cnt_seq: request side (InValid/InReady, operand, op)
// and result side (OutValid/OutReady, Result) plus Flush and Busy.
interface openhw_cnt_seq_if #(
  parameter int WIDTH = 64
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A;
  logic [1:0]       Op;
  logic             W64;
  logic             Flush;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic             Busy;

  modport master (
    output InValid, A, Op, W64, Flush, OutReady,
    input  InReady, OutValid, Result, Busy
  );

  modport slave (
    input  InValid, A, Op, W64, Flush, OutReady,
    output InReady, OutValid, Result, Busy
  );
endinterface

// File: rtl/openhw_cnt_seq.sv
// Iterative clz/ctz/cpop unit scanning CHUNK bits per cycle from the operand MSB.
// Optional macro OPENHW_CNT_EARLY_EXIT_EN: clz/ctz finish on the first nonzero chunk.
module openhw_cnt_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  openhw_cnt_seq_if.slave bus
);
  localparam int AW   = $clog2(WIDTH) + 1;
  localparam int NMAX = WIDTH / CHUNK;
  localparam int CW   = $clog2(NMAX) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] x, x_n;
  logic [1:0]       op, op_n;
  logic [CW-1:0]    n, n_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [AW-1:0]    acc, acc_n;
  logic             found, found_n;

  logic             word;
  logic [WIDTH-1:0] rev;
  logic [31:0]      rev32;
  logic [WIDTH-1:0] pre;
  logic [CHUNK-1:0] c;
  logic [AW-1:0]    pc;
  logic [AW-1:0]    lz;
  logic             hit;

  // ctz is turned into clz by bit-reversing; word mode parks the low word at the top.
  always_comb begin
    word  = (WIDTH == 64) ? bus.W64 : 1'b0;
    rev   = '0;
    rev32 = '0;
    for (int unsigned i = 0; i < WIDTH; i++) rev[i] = bus.A[WIDTH-1-i];
    for (int unsigned i = 0; i < 32; i++) rev32[i] = bus.A[31-i];
    pre = '0;
    if (word) begin
      pre[WIDTH-1 -: 32] = (bus.Op == 2'b01) ? rev32 : bus.A[31:0];
    end else begin
      pre = (bus.Op == 2'b01) ? rev : bus.A;
    end
  end

  always_comb begin
    c   = x[WIDTH-1 -: CHUNK];
    pc  = '0;
    lz  = AW'(CHUNK);
    hit = 1'b0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      pc = pc + AW'(c[i]);
      if (!hit && c[CHUNK-1-i]) begin
        lz  = AW'(i);
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    op_n    = op;
    n_n     = n;
    cnt_n   = cnt;
    acc_n   = acc;
    found_n = found;
    case (state)
      IDLE: begin
        if (bus.InValid) begin
          state_n = RUN;
          x_n     = pre;
          op_n    = bus.Op;
          n_n     = word ? CW'(32 / CHUNK) : CW'(NMAX);
          cnt_n   = '0;
          acc_n   = '0;
          found_n = 1'b0;
        end
      end
      RUN: begin
        x_n   = x << CHUNK;
        cnt_n = cnt + 1'b1;
        if (op[1]) begin
          acc_n = acc + pc;
        end else if (!found) begin
          acc_n = acc + lz;
        end
        found_n = found | (|c);
        if (cnt_n == n) state_n = DONE;
`ifdef OPENHW_CNT_EARLY_EXIT_EN
        if (!op[1] && !found && (|c)) state_n = DONE;
`endif
      end
      DONE: begin
        if (bus.OutReady) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (bus.Flush) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      x     <= '0;
      op    <= '0;
      n     <= '0;
      cnt   <= '0;
      acc   <= '0;
      found <= 1'b0;
    end else begin
      state <= state_n;
      x     <= x_n;
      op    <= op_n;
      n     <= n_n;
      cnt   <= cnt_n;
      acc   <= acc_n;
      found <= found_n;
    end
  end

  // Result is gated by DONE so it reads zero everywhere else without a separate register.
  assign bus.InReady  = (state == IDLE);
  assign bus.Busy     = (state != IDLE);
  assign bus.OutValid = (state == DONE);
  assign bus.Result   = (state == DONE) ? WIDTH'(acc) : '0;
endmodule

// File: tb/tb_openhw_cnt_seq.sv
// Scoreboard bench for openhw_cnt_seq (64/8 and 32/4 instances); honours
// OPENHW_CNT_EARLY_EXIT_EN when computing expected latencies.
module tb_openhw_cnt_seq;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  openhw_cnt_seq_if #(.WIDTH(64)) bus ();
  openhw_cnt_seq_if #(.WIDTH(32)) bus32 ();

  openhw_cnt_seq #(.WIDTH(64), .CHUNK(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  openhw_cnt_seq #(.WIDTH(32), .CHUNK(4)) dut32 (
    .clk(clk), .reset_n(reset_n), .bus(bus32)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int res;
    int lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [63:0] a;
    logic [1:0]  op;
    logic        w;
    int          res;
  } vec_t;

  // Bit-serial reference: count from the relevant end of the effective operand.
  function automatic void model(input logic [63:0] a, input logic [1:0] op, input logic w,
                                input int width, input int chunk, output int res, output int lat);
    int  wd;
    bit  seen;
    wd   = (w && width == 64) ? 32 : width;
    res  = 0;
    seen = 1'b0;
    lat  = wd / chunk;
    if (op[1]) begin
      for (int i = 0; i < wd; i++) res += int'(a[i]);
    end else begin
      for (int k = 0; k < wd; k++) begin
        int b;
        b = (op == 2'b00) ? wd - 1 - k : k;
        if (!seen) begin
          if (a[b]) seen = 1'b1;
          else res++;
        end
      end
`ifdef OPENHW_CNT_EARLY_EXIT_EN
      if (seen) lat = res / chunk + 1;
`endif
    end
  endfunction

  task automatic start_op(input logic [63:0] a, input logic [1:0] op, input logic w, input int want);
    exp_t e;
    int r, l;
    model(a, op, w, 64, 8, r, l);
    e.res = (want >= 0) ? want : r;
    e.lat = l;
    sb.push_back(e);
    bus.A = a;
    bus.Op = op;
    bus.W64 = w;
    bus.InValid = 1'b1;
    @(posedge clk);
    #1 bus.InValid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.OutValid) lat = k;
    end
  endtask

  task automatic handshake();
    bus.OutReady = 1'b1;
    @(posedge clk);
    #1 bus.OutReady = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (bus.OutValid !== 1'b0) $display("FAIL reset_outvalid got=%b want=0", bus.OutValid);
    if (bus.OutValid !== 1'b0) failures++;
    checks++;
    if (bus.Result !== 64'd0) begin failures++; $display("FAIL reset_result got=%0d want=0", bus.Result); end
    checks++;
    if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.Busy); end
    checks++;
    if (bus.InReady !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b want=1", bus.InReady); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.InReady, bus.Busy, bus.OutValid} !== 3'b100) begin
      failures++;
      $display("FAIL idle_after_reset got=%b want=100", {bus.InReady, bus.Busy, bus.OutValid});
    end
  endtask

  task automatic test_counts();
    vec_t v[$];
    exp_t e;
    int lat;
    v.push_back('{64'h0000_0000_0001_0000, 2'b00, 1'b0, 47});
    v.push_back('{64'h8000_0000_0000_0000, 2'b01, 1'b0, 63});
    v.push_back('{64'hFFFF_FFFF_0000_0000, 2'b01, 1'b1, 32});
    v.push_back('{64'h0000_0000_0000_0000, 2'b00, 1'b0, 64});
    v.push_back('{64'h0000_0000_0000_0000, 2'b01, 1'b1, 32});
    v.push_back('{64'hFFFF_FFFF_0000_000F, 2'b10, 1'b1, 4});
    v.push_back('{64'hFFFF_FFFF_0000_000F, 2'b10, 1'b0, 36});
    v.push_back('{64'hFFFF_FFFF_0000_000F, 2'b11, 1'b0, 36});
    v.push_back('{64'h0000_0000_0000_0001, 2'b00, 1'b0, 63});
    v.push_back('{64'h0000_0000_0000_0001, 2'b01, 1'b0, 0});
    v.push_back('{64'h0000_0000_8000_0000, 2'b00, 1'b1, 0});
    v.push_back('{64'h0000_0000_8000_0000, 2'b00, 1'b0, 32});
    foreach (v[i]) begin
      start_op(v[i].a, v[i].op, v[i].w, v[i].res);
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if (bus.Result !== 64'(e.res)) begin
        failures++;
        $display("FAIL count_result[%0d] got=%0d want=%0d", i, bus.Result, e.res);
      end
      checks++;
      if (lat !== e.lat) begin
        failures++;
        $display("FAIL count_latency[%0d] got=%0d want=%0d", i, lat, e.lat);
      end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    logic [63:0] a;
    for (int i = 0; i < 10; i++) begin
      a = {$urandom, $urandom} >> $urandom_range(0, 63);
      start_op(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if (bus.Result !== 64'(e.res)) begin
        failures++;
        $display("FAIL rand_result[%0d] a=%h got=%0d want=%0d", i, a, bus.Result, e.res);
      end
      checks++;
      if (lat !== e.lat) begin
        failures++;
        $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, e.lat);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat;
    start_op(64'h00FF_0000_0000_0000, 2'b00, 1'b0, 8);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin failures++; $display("FAIL bp_latency got=%0d want=%0d", lat, e.lat); end
    bus.InValid = 1'b1;
    bus.A = 64'h1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.OutValid, bus.InReady, bus.Busy} !== 3'b101 || bus.Result !== 64'(e.res)) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v/r/b=%b res=%0d want 101 res=%0d", k,
                 {bus.OutValid, bus.InReady, bus.Busy}, bus.Result, e.res);
      end
    end
    bus.OutReady = 1'b1;
    @(posedge clk);
    #1;
    bus.OutReady = 1'b0;
    bus.InValid = 1'b0;
    checks++;
    if ({bus.OutValid, bus.InReady, bus.Busy} !== 3'b010 || bus.Result !== 64'd0) begin
      failures++;
      $display("FAIL bp_release got v/r/b=%b res=%0d want 010 res=0",
               {bus.OutValid, bus.InReady, bus.Busy}, bus.Result);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    int lat;
    int seen;
    bus.A = 64'h0;
    bus.Op = 2'b00;
    bus.W64 = 1'b0;
    bus.InValid = 1'b1;
    @(posedge clk);
    #1 bus.InValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.Flush = 1'b1;
    bus.InValid = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
    bus.InValid = 1'b0;
    checks++;
    if ({bus.OutValid, bus.InReady, bus.Busy} !== 3'b010) begin
      failures++;
      $display("FAIL flush_run got v/r/b=%b want 010", {bus.OutValid, bus.InReady, bus.Busy});
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.OutValid) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL flush_no_output got=%0d want=0", seen); end
    start_op(64'h0000_0100_0000_0000, 2'b01, 1'b0, 40);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (bus.Result !== 64'(e.res) || lat !== e.lat) begin
      failures++;
      $display("FAIL flush_fresh got res=%0d lat=%0d want res=%0d lat=%0d", bus.Result, lat, e.res, e.lat);
    end
    bus.Flush = 1'b1;
    @(posedge clk);
    #1 bus.Flush = 1'b0;
    checks++;
    if ({bus.OutValid, bus.InReady, bus.Busy} !== 3'b010 || bus.Result !== 64'd0) begin
      failures++;
      $display("FAIL flush_done got v/r/b=%b res=%0d want 010 res=0",
               {bus.OutValid, bus.InReady, bus.Busy}, bus.Result);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int lat;
    start_op(64'h0, 2'b10, 1'b0, -1);
    e = sb.pop_front();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.OutValid, bus.InReady, bus.Busy} !== 3'b010 || bus.Result !== 64'd0) begin
      failures++;
      $display("FAIL areset_run got v/r/b=%b res=%0d want 010 res=0",
               {bus.OutValid, bus.InReady, bus.Busy}, bus.Result);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    start_op(64'hF, 2'b10, 1'b0, 4);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (bus.Result !== 64'(e.res)) begin failures++; $display("FAIL areset_pre got=%0d want=%0d", bus.Result, e.res); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.OutValid, bus.InReady, bus.Busy} !== 3'b010 || bus.Result !== 64'd0) begin
      failures++;
      $display("FAIL areset_done got v/r/b=%b res=%0d want 010 res=0",
               {bus.OutValid, bus.InReady, bus.Busy}, bus.Result);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_w32();
    vec_t v[$];
    exp_t e;
    int r, l, lat;
    v.push_back('{64'h0000_0100, 2'b00, 1'b1, 23});
    v.push_back('{64'h0000_0100, 2'b01, 1'b0, 8});
    v.push_back('{64'hFFFF_FFFF, 2'b10, 1'b0, 32});
    v.push_back('{64'h0000_0000, 2'b00, 1'b0, 32});
    foreach (v[i]) begin
      model(v[i].a, v[i].op, 1'b0, 32, 4, r, l);
      e.res = v[i].res;
      e.lat = l;
      sb.push_back(e);
      bus32.A = v[i].a[31:0];
      bus32.Op = v[i].op;
      bus32.W64 = v[i].w;
      bus32.InValid = 1'b1;
      @(posedge clk);
      #1 bus32.InValid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 100 && lat < 0; k++) begin
        @(posedge clk);
        #1;
        if (bus32.OutValid) lat = k;
      end
      e = sb.pop_front();
      checks++;
      if (bus32.Result !== 32'(e.res)) begin
        failures++;
        $display("FAIL w32_result[%0d] got=%0d want=%0d", i, bus32.Result, e.res);
      end
      checks++;
      if (lat !== e.lat) begin
        failures++;
        $display("FAIL w32_latency[%0d] got=%0d want=%0d", i, lat, e.lat);
      end
      bus32.OutReady = 1'b1;
      @(posedge clk);
      #1 bus32.OutReady = 1'b0;
    end
  endtask

  initial begin
    bus.InValid = 1'b0;
    bus.A = '0;
    bus.Op = '0;
    bus.W64 = 1'b0;
    bus.Flush = 1'b0;
    bus.OutReady = 1'b0;
    bus32.InValid = 1'b0;
    bus32.A = '0;
    bus32.Op = '0;
    bus32.W64 = 1'b0;
    bus32.Flush = 1'b0;
    bus32.OutReady = 1'b0;
    test_reset();
    test_counts();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_w32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
